// File: rtl/bus_sync_launcher.sv
// Source-side launcher for a multi-flop data synchronizer: holds each word with its
// enable high for HOLD_CYCLES, then forces a GAP_CYCLES low gap; one pending slot.
module bus_sync_launcher #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BUS_WIDTH-1:0] bus_reg, bus_next;
  logic                 enable_reg, enable_next;
  logic                 pend_full_reg, pend_full_next;
  logic [BUS_WIDTH-1:0] pend_data_reg, pend_data_next;

  logic                 accept;
  logic                 launch;
  logic [BUS_WIDTH-1:0] launch_data;

  // Ready depends only on the registered pending flag, never on in_valid.
  assign accept = in_valid & ~pend_full_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bus_reg       <= '0;
      enable_reg    <= 1'b0;
      pend_full_reg <= 1'b0;
      pend_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bus_reg       <= bus_next;
      enable_reg    <= enable_next;
      pend_full_reg <= pend_full_next;
      pend_data_reg <= pend_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bus_next       = bus_reg;
    enable_next    = enable_reg;
    pend_full_next = pend_full_reg;
    pend_data_next = pend_data_reg;
    launch         = 1'b0;
    launch_data    = in_data;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          launch = 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_reg == '0) begin
          enable_next = 1'b0;
          cnt_next    = GAP_LOAD;
          state_next  = ST_GAP;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
        if (accept) begin
          pend_full_next = 1'b1;
          pend_data_next = in_data;
        end
      end

      ST_GAP: begin
        if (cnt_reg == '0) begin
          // A word offered on the very last gap cycle launches directly so the
          // pending slot is never left occupied on the way into IDLE.
          if (pend_full_reg) begin
            launch         = 1'b1;
            launch_data    = pend_data_reg;
            pend_full_next = 1'b0;
          end else if (accept) begin
            launch = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
          if (accept) begin
            pend_full_next = 1'b1;
            pend_data_next = in_data;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        enable_next    = 1'b0;
        pend_full_next = 1'b0;
      end
    endcase

    if (launch) begin
      bus_next    = launch_data;
      enable_next = 1'b1;
      cnt_next    = HOLD_LOAD;
      state_next  = ST_HOLD;
    end
  end

  always_comb begin
    in_ready   = ~pend_full_reg;
    unsync_bus = bus_reg;
    bus_enable = enable_reg;
    busy       = (state_reg != ST_IDLE) | pend_full_reg;
  end

  a_idle_never_pending: assert property (@(posedge CLK) disable iff (!RST)
    (state_reg == ST_IDLE) |-> !pend_full_reg);

  a_bus_frozen_while_high: assert property (@(posedge CLK) disable iff (!RST)
    (enable_reg && $past(enable_reg)) |-> $stable(bus_reg));

endmodule

// File: tb/tb_bus_sync_launcher.sv
// Scoreboard bench for bus_sync_launcher: a default instance and a HOLD=1/GAP=1 instance,
// each checked cycle by cycle against a word-history model and a launch scoreboard.
`timescale 1ns/1ps
module tb_bus_sync_launcher;

  logic CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  int checks = 0;
  int errors = 0;

  // One accepted word: accept edge, edge on which its enable rises, and data.
  typedef struct {
    int         a;
    int         r;
    logic [7:0] d;
  } word_t;

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h, expected %0h (t=%0t)", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int H = (gi == 0) ? 4 : 1;
    localparam int G = (gi == 0) ? 2 : 1;

    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       busy;

    word_t hist[$];
    word_t exp_q[$];
    int    edge_n  = 0;
    bit    done    = 1'b0;
    logic  prev_en = 1'b0;

    bus_sync_launcher #(
      .BUS_WIDTH  (8),
      .HOLD_CYCLES(H),
      .GAP_CYCLES (G)
    ) u_dut (
      .CLK       (CLK_tb),
      .RST       (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .unsync_bus(unsync_bus),
      .bus_enable(bus_enable),
      .busy      (busy)
    );

    // Expected output values just after edge e, derived from the word history.
    function automatic bit ready_at(int e);
      foreach (hist[i]) if (hist[i].a <= e && e < hist[i].r) return 1'b0;
      return 1'b1;
    endfunction

    function automatic bit busy_at(int e);
      foreach (hist[i]) if (hist[i].a <= e && e < hist[i].r + H + G) return 1'b1;
      return 1'b0;
    endfunction

    function automatic bit en_at(int e);
      foreach (hist[i]) if (hist[i].r <= e && e < hist[i].r + H) return 1'b1;
      return 1'b0;
    endfunction

    function automatic logic [7:0] bus_at(int e);
      logic [7:0] v = 8'h00;
      foreach (hist[i]) if (hist[i].r <= e) v = hist[i].d;
      return v;
    endfunction

    initial begin : model
      word_t w;
      forever begin
        @(posedge CLK_tb);
        edge_n++;
        if (rst_n === 1'b1 && in_valid === 1'b1 && ready_at(edge_n - 1)) begin
          w.a = edge_n;
          w.r = edge_n;
          if (hist.size() > 0 && hist[$].r + H + G > w.r) w.r = hist[$].r + H + G;
          w.d = in_data;
          hist.push_back(w);
          exp_q.push_back(w);
        end
      end
    end

    initial begin : monitor
      word_t w;
      forever begin
        @(negedge CLK_tb);
        chk(gi, "in_ready", 32'(in_ready), 32'(ready_at(edge_n)));
        chk(gi, "busy", 32'(busy), 32'(busy_at(edge_n)));
        chk(gi, "bus_enable", 32'(bus_enable), 32'(en_at(edge_n)));
        chk(gi, "unsync_bus", 32'(unsync_bus), 32'(bus_at(edge_n)));
        if (bus_enable === 1'b1 && prev_en === 1'b0) begin
          chk(gi, "rise_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk(gi, "rise_data", 32'(unsync_bus), 32'(w.d));
            chk(gi, "rise_edge", 32'(edge_n), 32'(w.r));
            $display("inst%0d launch %02h accepted edge %0d rose edge %0d", gi, unsync_bus, w.a, edge_n);
          end
        end
        prev_en = bus_enable;
      end
    end

    task automatic send(input logic [7:0] d);
      int n0;
      bit got;
      n0 = hist.size();
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 40 && !got; i++) begin
        @(posedge CLK_tb);
        #1;
        got = (hist.size() != n0);
      end
      chk(gi, "accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge CLK_tb);
      #1;
    endtask

    task automatic check_reset_values(input string tag);
      chk(gi, {tag, "_unsync_bus"}, 32'(unsync_bus), 32'h0);
      chk(gi, {tag, "_bus_enable"}, 32'(bus_enable), 32'h0);
      chk(gi, {tag, "_in_ready"}, 32'(in_ready), 32'h1);
      chk(gi, {tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin : driver
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge CLK_tb);
      #1;
      check_reset_values("reset");
      @(negedge CLK_tb);
      #1 rst_n = 1'b1;
      @(posedge CLK_tb);
      #1;

      send(8'hAB);
      idle(H + G + 3);

      send(8'hAB);
      send(8'hCD);
      idle(2 * (H + G) + 3);

      send(8'h11);
      send(8'h22);
      send(8'h33);
      idle(3 * (H + G) + 3);

      // Reset while the first word is held and the second is pending.
      send(8'hAB);
      send(8'hCD);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      hist.delete();
      exp_q.delete();
      #1;
      check_reset_values("midrst");
      @(posedge CLK_tb);
      @(negedge CLK_tb);
      #1 rst_n = 1'b1;
      @(posedge CLK_tb);
      #1;
      send(8'hCD);
      idle(H + G + 3);

      repeat (60) begin
        if ($urandom_range(0, 3) != 0) send(8'($urandom));
        else idle(int'($urandom_range(1, H + G + 2)));
      end
      idle(3 * (H + G) + 4);
      chk(gi, "drain", 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin : top
    for (int i = 0; i < 20000 && !(g_inst[0].done && g_inst[1].done); i++) @(posedge CLK_tb);
    chk(9, "finish_timeout", 32'(g_inst[0].done && g_inst[1].done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sync_launcher.md
# bus_sync_launcher

Source-side companion to the multi-flop data synchronizer (`DATA_SYNC`). It accepts words over a valid/ready handshake and drives the synchronizer's `unsync_bus`/`bus_enable` pair. It holds each word and its enable level stable long enough for the destination-domain synchronizer chain to capture them. It then forces a low gap so the destination edge detector produces exactly one `enable_pulse` per word. A one-entry pending buffer lets the upstream producer hand off the next word while the current one is still being held.

## Interface

Parameters:

- `BUS_WIDTH`, 8, width of the data word; must match the synchronizer's `BUS_WIDTH`.
- `HOLD_CYCLES`, 4, number of source clock cycles that `bus_enable` stays high per word. Must be ≥1 and must cover at least `NUM_STAGES`+1 destination clock periods.
- `GAP_CYCLES`, 2, minimum number of source clock cycles that `bus_enable` stays low between words. Must be ≥1 and must cover at least `NUM_STAGES`+1 destination clock periods.

Ports:

- `CLK`, input, 1, single source-domain clock; all logic is on the rising edge.
- `RST`, input, 1, asynchronous active-low reset.
- `in_data`, input, `BUS_WIDTH`, word to transfer.
- `in_valid`, input, 1, `in_data` is valid.
- `in_ready`, output, 1, block can accept a word this cycle; a transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `unsync_bus`, output, `BUS_WIDTH`, registered data to the synchronizer.
- `bus_enable`, output, 1, registered enable level to the synchronizer.
- `busy`, output, 1, high while a word is being held or gapped, or while a word is pending.

## Operation

- **Reset (asynchronous, `RST`=0):**
  - `unsync_bus`=0, `bus_enable`=0, `in_ready`=1, `busy`=0.
  - State returns to IDLE, the cycle counter clears, and the pending buffer is emptied.
  - Reset asserted mid-transfer discards both the held word and the pending word, and drops `bus_enable` immediately.
- **State machine: IDLE, HOLD, GAP.**
  - **IDLE:** on a transfer, load `in_data` into `unsync_bus`, set `bus_enable`=1, load counter=`HOLD_CYCLES`-1, and go to HOLD. The pending buffer is always empty in IDLE.
  - **HOLD:** `bus_enable`=1 and `unsync_bus` is frozen. The counter decrements each cycle. When the counter is 0, clear `bus_enable`, load counter=`GAP_CYCLES`-1, and go to GAP.
  - **GAP:** `bus_enable`=0 and `unsync_bus` stays frozen at the last word; it is never changed while the enable is low. When the counter is 0:
    - if a word is pending, load it into `unsync_bus`, set `bus_enable`=1, reload counter=`HOLD_CYCLES`-1, mark pending empty, and go to HOLD;
    - otherwise go to IDLE.
- **Pending buffer:**
  - `in_ready` = !pending_full; it is combinational from the registered pending flag only, with no combinational path from `in_valid`.
  - A transfer accepted while in HOLD or GAP is stored in the pending buffer.
- **Simultaneous events:** if GAP ends with pending full, `in_ready` is 0 that cycle. The pending word launches, and `in_ready` returns to 1 on the next cycle.
- `busy` = (state != IDLE) | pending_full.
- **Throughput:** at most one word per `HOLD_CYCLES`+`GAP_CYCLES` cycles. The counter width is clog2(max(`HOLD_CYCLES`,`GAP_CYCLES`)), minimum 1 bit.

## Timing

- **Latency:** a transfer at edge k makes `unsync_bus`=word and `bus_enable`=1 visible after edge k (one-cycle latency, registered outputs).
- **HOLD duration:** `bus_enable` is high for exactly `HOLD_CYCLES` cycles, falling after edge k+`HOLD_CYCLES`.
- **GAP duration:** `bus_enable` is low for exactly `GAP_CYCLES` cycles before a pending word rises. If no word is pending, it stays low until the next transfer.
- **Stability:** `unsync_bus` changes only on the same edge where `bus_enable` rises, and never while `bus_enable` is high.
- **Back-to-back pending:** with a word pending, the next rise of `bus_enable` occurs `HOLD_CYCLES`+`GAP_CYCLES` cycles after the previous rise.
- **`busy`:** rises on the edge after the first transfer. It falls on the edge where GAP exits to IDLE.

## Test plan

- **Reset values:** assert `RST`=0 for 1 cycle, then release. Required: `unsync_bus`=0, `bus_enable`=0, `in_ready`=1, `busy`=0.
- **Single word (defaults):**
  - Stimulus: transfer 8'hAB.
  - Required: `bus_enable` high for exactly 4 cycles with `unsync_bus`=8'hAB, then low. `busy` clears 6 cycles after the transfer.
  - With `DATA_SYNC` attached: exactly one `enable_pulse`, with `sync_bus`=8'hAB.
- **Back-to-back words:**
  - Stimulus: transfer 8'hAB, then offer 8'hCD on the next cycle.
  - Required: 8'hCD is accepted, then `in_ready`=0 until the 8'hCD launch. `bus_enable` rises for 8'hCD exactly 6 cycles after the 8'hAB rise.
- **Held valid:** hold `in_valid`=1 while presenting 3 words. Required: each word is accepted exactly once, in order, with no word dropped or duplicated. The DATA_SYNC output shows 3 pulses carrying values 8'h11, 8'h22, 8'h33.
- **Reset mid-transfer:**
  - Stimulus: assert `RST`=0 during HOLD with a word pending.
  - Required: `bus_enable` drops immediately, both words are lost, and all outputs take their reset values.
  - After release, transfer 8'hCD. Required: normal single-word behaviour.
- **Parameter sweep:** `HOLD_CYCLES`=1, `GAP_CYCLES`=1. Required: the enable alternates high for 1 cycle and low for 1 cycle under a continuous stream, and `unsync_bus` changes only on rising edges of `bus_enable`.
